// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the one-hot result codes and an elaboration-time log2.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result vector layout is {eq, gt, lt}; exactly one bit set once valid.
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_slice2.sv
// Combinational 2-bit unsigned compare of one operand slice.
// Same slice primitive used by the small single-cycle comparators.
module cmp_slice2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       s_eq,
    output logic       s_gt,
    output logic       s_lt
);

    assign s_eq = (i_a == i_b);
    assign s_gt = (i_a >  i_b);
    assign s_lt = (i_a <  i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned comparator walking WIDTH-bit operands MSB-first, 2 bits per clock.
// Optional macro SEQ_CMP_EARLY_EXIT_EN: finish on the first unequal slice instead of walking all slices.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("seq_magnitude_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_res;
    logic             r_found;
    logic             r_busy;
    logic             r_done;

    logic [1:0] w_a_sl [SLICES];
    logic [1:0] w_b_sl [SLICES];
    logic [1:0] w_sa;
    logic [1:0] w_sb;
    logic       w_s_eq;
    logic       w_s_gt;
    logic       w_s_lt;
    logic       w_mismatch;
    logic       w_last;
    logic       w_finish;

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign w_a_sl[gi] = r_a[2*gi +: 2];
            assign w_b_sl[gi] = r_b[2*gi +: 2];
        end
    endgenerate

    assign w_sa = w_a_sl[r_idx];
    assign w_sb = w_b_sl[r_idx];

    cmp_slice2 u_slice (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .s_eq (w_s_eq),
        .s_gt (w_s_gt),
        .s_lt (w_s_lt)
    );

    // Only the first unequal slice may write the result.
    assign w_mismatch = !r_found && !w_s_eq;
    assign w_last     = (r_idx == '0);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_finish   = w_last || w_mismatch;
`else
    assign w_finish   = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_res   <= '0;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= IDX_LAST;
                        r_res   <= '0;
                        r_found <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CMP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CMP: begin
                    if (w_mismatch) begin
                        r_res   <= w_s_gt ? RES_GT : RES_LT;
                        r_found <= 1'b1;
                    end
                    if (w_finish) begin
                        if (w_last && !r_found && w_s_eq) begin
                            r_res <= RES_EQ;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign eq   = r_res[2];
    assign gt   = r_res[1];
    assign lt   = r_res[0];

    // w_s_lt is implied by the other two flags; kept for interface symmetry.
    logic w_unused;
    assign w_unused = w_s_lt;

endmodule
